// File: rtl/voice_mixer.sv
// voice_mixer: eight-voice square-wave synth, one voice per clock through a shared multiplier, mixed to a 48 kHz sample
module voice_mixer #(
  parameter int SAMPLE_RATE = 48000,
  parameter int VOICES = 8,
  parameter int AMPLITUDE = 4095
) (
  input  logic clk,
  input  logic reset,
  input  logic [31:0] clock_frequency,
  input  logic [15:0] frequencies [VOICES-1:0],
  input  logic [31:0] voice_volumes [VOICES-1:0],
  output logic signed [15:0] audio_out,
  output logic sample_valid
);
  localparam int IW = $clog2(VOICES);
  localparam logic [21:0] MOD = 22'(SAMPLE_RATE * 32);
  localparam logic [20:0] HALF = 21'(SAMPLE_RATE * 16);
  localparam logic [31:0] UNITY = 32'h0010_0000;
  typedef enum logic [1:0] {IDLE, SNAP, VOICE, EMIT} state_t;
  state_t state;
  logic [31:0] acc;
  logic [20:0] phase [VOICES-1:0];
  logic [15:0] freq_s [VOICES-1:0];
  logic [31:0] vol_s [VOICES-1:0];
  logic [IW-1:0] idx;
  logic signed [19:0] sum;
  logic [32:0] acc_inc;
  logic tick;
  logic [15:0] f;
  logic [31:0] vol;
  logic [20:0] v;
  logic [35:0] prod;
  logic signed [19:0] mag;
  logic signed [19:0] contrib;
  logic silent;
  logic [21:0] ph_sum;
  logic [20:0] ph_next;
  logic signed [15:0] sat;
  always_comb begin
    acc_inc = {1'b0, acc} + 33'(SAMPLE_RATE);
    tick = acc_inc >= {1'b0, clock_frequency};
    f = freq_s[idx];
    vol = vol_s[idx];
    v = vol > UNITY ? UNITY[20:0] : vol[20:0];
    prod = 36'(AMPLITUDE) * 36'(v);
    mag = $signed(20'(prod >> 20));
    silent = f == '0 || vol == '0;
    contrib = silent ? '0 : phase[idx] < HALF ? mag : -mag;
    ph_sum = {1'b0, phase[idx]} + 22'(f);
    ph_next = silent ? '0 : ph_sum >= MOD ? 21'(ph_sum - MOD) : ph_sum[20:0];
    sat = sum > 20'sd32767 ? 16'sh7fff : sum < -20'sd32767 ? -16'sh7fff : sum[15:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      idx <= '0;
      sum <= '0;
      audio_out <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        phase[i] <= '0;
        freq_s[i] <= '0;
        vol_s[i] <= '0;
      end
    end else begin
      acc <= tick ? 32'(acc_inc - {1'b0, clock_frequency}) : acc_inc[31:0];
      sample_valid <= 1'b0;
      case (state)
        IDLE: if (tick) state <= SNAP;
        SNAP: begin
          freq_s <= frequencies;
          vol_s <= voice_volumes;
          sum <= '0;
          idx <= '0;
          state <= VOICE;
        end
        VOICE: begin
          sum <= sum + contrib;
          phase[idx] <= ph_next;
          idx <= idx + IW'(1);
          if (idx == IW'(VOICES - 1)) state <= EMIT;
        end
        EMIT: begin
          audio_out <= sat;
          sample_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: table vectors, boundary sequences and random stimulus against an arithmetic model of the mixer
module tb_voice_mixer;
  localparam longint SR = 48000;
  localparam longint M = 1536000;
  localparam logic [31:0] FAST = 32'd576000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] clock_frequency = 32'd24000000;
  logic [15:0] frequencies [7:0];
  logic [31:0] voice_volumes [7:0];
  logic signed [15:0] audio_out;
  logic sample_valid;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  longint ph [8];
  typedef struct {
    int voice;
    logic [15:0] freq;
    logic [31:0] vol;
    longint exp0;
  } vec_t;
  voice_mixer dut (
    .clk(clk),
    .reset(reset),
    .clock_frequency(clock_frequency),
    .frequencies(frequencies),
    .voice_volumes(voice_volumes),
    .audio_out(audio_out),
    .sample_valid(sample_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  // Square wave per voice: sign from the phase before this sample's advance
  function automatic longint model_sample();
    longint s, f, vol, mag;
    s = 0;
    for (int v = 0; v < 8; v++) begin
      f = longint'(frequencies[v]);
      vol = longint'(voice_volumes[v]);
      if (f == 0 || vol == 0) begin
        ph[v] = 0;
        continue;
      end
      mag = (4095 * (vol > 1048576 ? 1048576 : vol)) / 1048576;
      s += ph[v] < M / 2 ? mag : -mag;
      ph[v] = (ph[v] + f) % M;
    end
    return s > 32767 ? 32767 : s < -32767 ? -32767 : s;
  endfunction
  task automatic wait_sample(input string nm, output int at);
    at = -1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid) begin
        at = cyc;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no sample_valid within 1000 cycles", nm);
  endtask
  task automatic next_sample(input string nm, output longint got, output int at);
    wait_sample(nm, at);
    got = longint'(audio_out);
    check(nm, got, model_sample());
  endtask
  task automatic clear_voices();
    for (int v = 0; v < 8; v++) begin
      frequencies[v] = '0;
      voice_volumes[v] = '0;
    end
  endtask
  task automatic do_reset(input int n, input logic [31:0] cf);
    reset = 1'b1;
    clock_frequency = cf;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("reset_audio", longint'(audio_out), 0);
      check("reset_valid", longint'(sample_valid), 0);
    end
    reset = 1'b0;
    for (int v = 0; v < 8; v++) ph[v] = 0;
  endtask
  initial begin
    vec_t tbl [8];
    logic [31:0] cfs [3];
    longint got;
    int at;
    int r;
    tbl[0] = '{0, 16'd3520, 32'h0010_0000, 4095};
    tbl[1] = '{1, 16'd3520, 32'h0008_0000, 2047};
    tbl[2] = '{2, 16'd3520, 32'h0100_0000, 4095};
    tbl[3] = '{3, 16'd3520, 32'h0000_0000, 0};
    tbl[4] = '{4, 16'd0, 32'h0010_0000, 0};
    tbl[5] = '{5, 16'd4400, 32'h000C_0000, 3071};
    tbl[6] = '{6, 16'd65535, 32'd12345, 48};
    tbl[7] = '{7, 16'd65535, 32'hFFFF_FFFF, 4095};
    cfs[0] = 32'd24000000;
    cfs[1] = 32'd24024000;
    cfs[2] = 32'd24000100;
    for (int v = 0; v < 8; v++) begin
      frequencies[v] = 16'($urandom);
      voice_volumes[v] = $urandom;
    end
    do_reset(5, cfs[0]);
    // Tick n lands in cycle ceil(n*cf/SR); the sample shows 10 edges later
    for (int c = 0; c < 3; c++) begin
      if (c > 0) do_reset(3, cfs[c]);
      clear_voices();
      frequencies[2] = 16'd3520;
      voice_volumes[2] = 32'h0010_0000;
      for (int n = 1; n <= 4; n++) begin
        next_sample($sformatf("div_audio_cf%0d", c), got, at);
        check($sformatf("div_time_cf%0d_n%0d", c, n), at, (longint'(n) * longint'(cfs[c]) + SR - 1) / SR + 10);
        @(posedge clk);
        #1;
        check("valid_one_cycle", longint'(sample_valid), 0);
      end
    end
    do_reset(2, FAST);
    clear_voices();
    frequencies[0] = 16'd3520;
    voice_volumes[0] = 32'h0010_0000;
    for (int n = 0; n <= 437; n++) begin
      next_sample("single", got, at);
      if (n == 0 || n == 218 || n == 219 || n == 436 || n == 437)
        check($sformatf("single_n%0d", n), got, (n == 219 || n == 436) ? -4095 : 4095);
    end
    do_reset(2, FAST);
    clear_voices();
    frequencies[0] = 16'd3520;
    voice_volumes[0] = 32'h0010_0000;
    frequencies[6] = 16'd4400;
    voice_volumes[6] = 32'h0010_0000;
    next_sample("two", got, at);
    check("two_first", got, 8190);
    voice_volumes[0] = '0;
    for (int n = 0; n < 3; n++) begin
      next_sample("two_release", got, at);
      check("two_release_mag", got < 0 ? -got : got, 4095);
      check("release_phase0", longint'(dut.phase[0]), 0);
    end
    for (int i = 0; i < 8; i++) begin
      do_reset(2, FAST);
      clear_voices();
      frequencies[tbl[i].voice] = tbl[i].freq;
      voice_volumes[tbl[i].voice] = tbl[i].vol;
      next_sample($sformatf("vec%0d_model", i), got, at);
      check($sformatf("vec%0d", i), got, tbl[i].exp0);
    end
    do_reset(2, FAST);
    clear_voices();
    frequencies[3] = 16'd65535;
    voice_volumes[3] = 32'h0008_0000;
    for (int n = 0; n <= 12; n++) begin
      next_sample("half_vol", got, at);
      if (n == 12) check("half_vol_neg", got, -2047);
    end
    do_reset(2, FAST);
    for (int v = 0; v < 8; v++) begin
      frequencies[v] = 16'd3520;
      voice_volumes[v] = 32'h0010_0000;
    end
    for (int n = 0; n <= 219; n++) begin
      next_sample("chord", got, at);
      if (n == 0 || n == 219) check($sformatf("chord_n%0d", n), got, n == 0 ? 32760 : -32760);
    end
    // Reset lands in the middle of the next sample's voice loop
    wait_sample("pre_abort", at);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_audio", longint'(audio_out), 0);
    check("abort_valid", longint'(sample_valid), 0);
    reset = 1'b0;
    for (int v = 0; v < 8; v++) ph[v] = 0;
    next_sample("post_abort", got, at);
    check("post_abort_time", at, 22);
    check("post_abort_value", got, 32760);
    do_reset(2, FAST);
    clear_voices();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) begin
        r = $urandom_range(7);
        frequencies[r] = $urandom_range(4) == 0 ? 16'd0 : 16'($urandom);
        case ($urandom_range(4))
          0: voice_volumes[r] = '0;
          1: voice_volumes[r] = 32'h0010_0000;
          2: voice_volumes[r] = $urandom_range(32'h0040_0000);
          3: voice_volumes[r] = $urandom;
          default: voice_volumes[r] = $urandom_range(32'h0010_0000);
        endcase
      end
      next_sample("random", got, at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
